// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with runtime almost-full/almost-empty
// thresholds, fill-level output, synchronous flush, any depth >= 2 and an
// optional first-word-fall-through read port.
//
// Ports
//   clk, rst_n    clock, synchronous active-low reset
//   data_in       write data          wr_en  write request
//   rd_en         read request (pop in FWFT mode)
//   flush         synchronous clear of contents
//   af_thresh     almostfull  when count >= af_thresh
//   ae_thresh     almostempty when count <= ae_thresh
//   data_out      read data (registered, or fall-through when FWFT=1)
//   wr_ack / overflow / underflow   one-cycle status pulses for the previous edge
//   full, empty, almostfull, almostempty, count   live fill status
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter bit FWFT       = 1'b0,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic [CW-1:0]         af_thresh,
  input  logic [CW-1:0]         ae_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  wr_acc, rd_acc;

  assign full        = (count == CW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  // Plain compares give the degenerate cases for free: af_thresh=0 always
  // holds, and ae_thresh >= depth always holds since count <= depth.
  assign almostfull  = (count >= af_thresh);
  assign almostempty = (count <= ae_thresh);

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_nxt(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_nxt(rd_ptr);
      count     <= count + CW'(wr_acc) - CW'(rd_acc);
      wr_ack    <= wr_acc;
      overflow  <= wr_en & ~wr_acc;
      underflow <= rd_en & ~rd_acc;
    end
  end

  // Storage is never reset; only written locations are ever read out.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && wr_acc) mem[wr_ptr] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      assign data_out = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [FIFO_WIDTH-1:0] dout_q;
      // Holds across rejected reads and flush; only reset clears it.
      always_ff @(posedge clk) begin
        if (!rst_n)                dout_q <= '0;
        else if (!flush && rd_acc) dout_q <= mem[rd_ptr];
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: a DEPTH=8 registered-read instance
// and a DEPTH=5 fall-through instance share stimulus; `sel` picks which one is
// compared against a queue-based reference model.
module tb_sync_fifo_prog;

  logic        clk = 1'b0;
  logic        rst_n, wr_en, rd_en, flush;
  logic [15:0] data_in;
  logic [3:0]  af_th, ae_th;

  logic [15:0] d0_dout, d1_dout;
  logic        d0_ack, d0_ovf, d0_udf, d0_full, d0_empty, d0_af, d0_ae;
  logic        d1_ack, d1_ovf, d1_udf, d1_full, d1_empty, d1_af, d1_ae;
  logic [3:0]  d0_cnt;
  logic [2:0]  d1_cnt;

  always #5 clk = ~clk;

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .flush(flush), .af_thresh(af_th), .ae_thresh(ae_th), .data_out(d0_dout),
    .wr_ack(d0_ack), .overflow(d0_ovf), .underflow(d0_udf), .full(d0_full),
    .empty(d0_empty), .almostfull(d0_af), .almostempty(d0_ae), .count(d0_cnt));

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .flush(flush), .af_thresh(af_th[2:0]), .ae_thresh(ae_th[2:0]), .data_out(d1_dout),
    .wr_ack(d1_ack), .overflow(d1_ovf), .underflow(d1_udf), .full(d1_full),
    .empty(d1_empty), .almostfull(d1_af), .almostempty(d1_ae), .count(d1_cnt));

  int checks = 0;
  int errors = 0;
  bit sel;   // 0: u0 (DEPTH 8, FWFT 0), 1: u1 (DEPTH 5, FWFT 1)

  // ---------------- reference model ----------------
  logic [15:0] mq[$];
  logic [15:0] m_dout;
  bit          m_ack, m_ovf, m_udf;

  function automatic int mdepth();
    return sel ? 5 : 8;
  endfunction

  task automatic model_step();
    bit wa, ra;
    if (!rst_n) begin
      mq.delete(); m_dout = '0; m_ack = 0; m_ovf = 0; m_udf = 0;
    end else if (flush) begin
      mq.delete(); m_ack = 0; m_ovf = 0; m_udf = 0;
    end else begin
      wa = wr_en && (mq.size() < mdepth());
      ra = rd_en && (mq.size() > 0);
      if (ra) m_dout = mq.pop_front();
      if (wa) mq.push_back(data_in);
      m_ack = wa; m_ovf = wr_en && !wa; m_udf = rd_en && !ra;
    end
  endtask

  // ---------------- DUT view ----------------
  function automatic logic [15:0] g_dout(); return sel ? d1_dout : d0_dout; endfunction
  function automatic logic [3:0]  g_cnt();  return sel ? {1'b0, d1_cnt} : d0_cnt; endfunction
  // {ack, ovf, udf}
  function automatic logic [2:0] g_pls();
    return sel ? {d1_ack, d1_ovf, d1_udf} : {d0_ack, d0_ovf, d0_udf};
  endfunction
  // {full, empty, almostfull, almostempty}
  function automatic logic [3:0] g_flg();
    return sel ? {d1_full, d1_empty, d1_af, d1_ae} : {d0_full, d0_empty, d0_af, d0_ae};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (sel=%0d t=%0t)", nm, act, exp, sel, $time);
    end
  endtask

  task automatic cmp_model();
    int n;
    logic [3:0] afv, aev;
    logic [15:0] ed;
    n   = mq.size();
    afv = sel ? {1'b0, af_th[2:0]} : af_th;
    aev = sel ? {1'b0, ae_th[2:0]} : ae_th;
    ed  = sel ? ((n == 0) ? 16'h0 : mq[0]) : m_dout;
    chk("model_count", 32'(g_cnt()), 32'(n));
    chk("model_dout",  32'(g_dout()), 32'(ed));
    chk("model_pulse", 32'(g_pls()), 32'({m_ack, m_ovf, m_udf}));
    chk("model_flags", 32'(g_flg()),
        32'({n == mdepth(), n == 0, n >= int'(afv), n <= int'(aev)}));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic drive(input bit w, input bit r, input bit f, input logic [15:0] d);
    wr_en = w; rd_en = r; flush = f; data_in = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; drive(1, 0, 0, 16'hFFFF);
    cyc(); cyc();
    rst_n = 1'b1; drive(0, 0, 0, 16'h0);
  endtask

  // ---------------- directed vector table (u0) ----------------
  typedef struct {
    bit          wr, rd, fl;
    logic [15:0] din;
    int          cnt;
    logic [15:0] dout;
    bit          ack, ovf, udf;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit w, input bit r, input bit f, input logic [15:0] d,
                     input int c, input logic [15:0] o, input bit a, input bit ov, input bit u);
    vec_t v;
    v.wr = w; v.rd = r; v.fl = f; v.din = d; v.cnt = c; v.dout = o;
    v.ack = a; v.ovf = ov; v.udf = u;
    vt.push_back(v);
  endtask

  initial begin
    vec_t v;
    // fill 1..8, then a rejected 9th write
    for (int i = 1; i <= 8; i++) add(1, 0, 0, 16'(i), i, 16'h0, 1, 0, 0);
    add(1, 0, 0, 16'h9, 8, 16'h0, 0, 1, 0);
    // drain in order, 9th read underflows and data_out holds 0008
    for (int j = 1; j <= 8; j++) add(0, 1, 0, 16'h0, 8 - j, 16'(j), 0, 0, 0);
    add(0, 1, 0, 16'h0, 0, 16'h8, 0, 0, 1);
    // simultaneous at count 4
    for (int k = 0; k < 4; k++) add(1, 0, 0, 16'h10 + 16'(k), k + 1, 16'h8, 1, 0, 0);
    add(1, 1, 0, 16'h20, 4, 16'h10, 1, 0, 0);
    // simultaneous at count 8: write rejected, read taken
    for (int k = 0; k < 4; k++) add(1, 0, 0, 16'h30 + 16'(k), 5 + k, 16'h10, 1, 0, 0);
    add(1, 1, 0, 16'h40, 7, 16'h11, 0, 1, 0);
    // flush (data_out holds), then simultaneous at count 0
    add(1, 1, 1, 16'h77, 0, 16'h11, 0, 0, 0);
    add(1, 1, 0, 16'h50, 1, 16'h11, 1, 0, 1);
    add(0, 1, 0, 16'h0, 0, 16'h50, 0, 0, 0);

    rst_n = 1'b0; flush = 0; wr_en = 0; rd_en = 0; data_in = 0;
    af_th = 4'd6; ae_th = 4'd2;
    sel = 0;
    @(negedge clk);

    // reset with wr_en=1 held for 2 edges, both instances
    do_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      chk("rst_count", 32'(g_cnt()), 32'd0);
      chk("rst_dout",  32'(g_dout()), 32'd0);
      chk("rst_pulse", 32'(g_pls()), 32'd0);
      chk("rst_full_empty", 32'(g_flg() >> 2), 32'b01);
    end
    sel = 0;

    // table on u0 with af=6, ae=2
    foreach (vt[i]) begin
      v = vt[i];
      drive(v.wr, v.rd, v.fl, v.din);
      cyc();
      chk($sformatf("vec%0d_count", i), 32'(g_cnt()), 32'(v.cnt));
      chk($sformatf("vec%0d_dout", i),  32'(g_dout()), 32'(v.dout));
      chk($sformatf("vec%0d_pulse", i), 32'(g_pls()), 32'({v.ack, v.ovf, v.udf}));
      chk($sformatf("vec%0d_flags", i), 32'(g_flg()),
          32'({v.cnt == 8, v.cnt == 0, v.cnt >= 6, v.cnt <= 2}));
    end
    drive(0, 0, 0, 16'h0);

    // threshold corners: af=0 forces almostfull, ae>=depth forces almostempty
    af_th = 4'd0; ae_th = 4'd8;
    #1;
    chk("af0_ae8_flags", 32'({d0_af, d0_ae}), 32'b11);
    af_th = 4'd6; ae_th = 4'd2;

    // fall-through instance
    sel = 1;
    do_reset();
    drive(1, 0, 0, 16'hA5A5);
    cyc();
    chk("fwft_first_dout", 32'(d1_dout), 32'hA5A5);
    chk("fwft_first_empty", 32'(d1_empty), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      drive(1, 1, 0, 16'hC000 + 16'(k));
      cyc();
      chk($sformatf("fwft_pair%0d_dout", k), 32'(d1_dout), 32'hC000 + 32'(k));
      chk($sformatf("fwft_pair%0d_count", k), 32'(d1_cnt), 32'd1);
    end
    drive(1, 0, 0, 16'hD001); cyc();
    drive(1, 0, 0, 16'hD002); cyc();
    chk("fwft_pre_flush_count", 32'(d1_cnt), 32'd3);
    drive(0, 0, 1, 16'h0);
    cyc();
    chk("fwft_flush_count", 32'(d1_cnt), 32'd0);
    chk("fwft_flush_empty", 32'(d1_empty), 32'd1);
    chk("fwft_flush_dout", 32'(d1_dout), 32'd0);
    drive(0, 0, 0, 16'h0);

    // randomized run against the model, each instance in turn
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      for (int n = 0; n < 600; n++) begin
        rst_n   = ($urandom_range(0, 149) != 0);
        flush   = ($urandom_range(0, 39) == 0);
        wr_en   = ($urandom_range(0, 99) < ((n / 100) % 2 ? 70 : 40));
        rd_en   = ($urandom_range(0, 99) < ((n / 100) % 2 ? 40 : 70));
        data_in = 16'($urandom);
        if ($urandom_range(0, 19) == 0) begin
          af_th = 4'($urandom_range(0, sel ? 7 : 9));
          ae_th = 4'($urandom_range(0, sel ? 7 : 9));
        end
        cyc();
      end
      rst_n = 1'b1;
      drive(0, 0, 0, 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
